// File: rtl/sdram_dq_path_if.sv
// Controller-side bus of sdram_dq_path: burst requests, write beat handshake
// and captured read beats. The controller uses master, the data path uses slave.
interface sdram_dq_path_if #(
  parameter int DATA_WIDTH = 16,
  parameter int MASK_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_W      = 9
);
  logic                  wr_start;
  logic                  rd_start;
  logic [LEN_W-1:0]      burst_len;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [MASK_WIDTH-1:0] wr_mask;
  logic                  wr_data_req;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output wr_start, rd_start, burst_len, wr_data, wr_mask,
    input  wr_data_req, rd_data, rd_valid
  );

  modport slave (
    input  wr_start, rd_start, burst_len, wr_data, wr_mask,
    output wr_data_req, rd_data, rd_valid
  );
endinterface

// File: rtl/sdram_dq_path.sv
// SDRAM DQ/DQM data path: registered write bursts onto the tristate bus and
// delayed read capture with a valid strobe. Define SDRAM_DQ_IOREG_EN for a pad input register.
module sdram_dq_path #(
  parameter int DATA_WIDTH = 16,
  parameter int MASK_WIDTH = DATA_WIDTH / 8,
  parameter int RD_DELAY   = 4,
  parameter int MAX_BURST  = 256,
  parameter int LEN_W      = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sdram_dq_path_if.slave        ctl,
  inout  wire  [DATA_WIDTH-1:0] sdram_dq,
  output logic [MASK_WIDTH-1:0] sdram_dqm,
  output logic                  bus_conflict
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WR   = 1'b1;

`ifdef SDRAM_DQ_IOREG_EN
  localparam int DL_DEPTH = RD_DELAY + 1;
`else
  localparam int DL_DEPTH = RD_DELAY;
`endif

  logic [LEN_W-1:0]      w_len;
  logic                  w_wr_beat;
  logic                  w_rd_pending;
  logic                  w_emerge;
  logic                  w_capture;
  logic [DATA_WIDTH-1:0] w_dq_cap;

  logic [0:0]            r_wr_state;
  logic [LEN_W-1:0]      r_wr_cnt;
  logic                  r_dq_oe;
  logic [DATA_WIDTH-1:0] r_dq_out;
  logic [MASK_WIDTH-1:0] r_dqm;
  logic [DL_DEPTH-1:0]   r_dl_vld;
  logic [LEN_W-1:0]      r_dl_len [DL_DEPTH];
  logic [LEN_W-1:0]      r_cap_cnt;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_conflict;

  // NOTE: every branch assigns w_len, so this stays purely combinational (no latch).
  always_comb begin
    w_len = ctl.burst_len;
    if (ctl.burst_len == '0)
      w_len = LEN_W'(1);
    else if (ctl.burst_len > LEN_W'(MAX_BURST))
      w_len = LEN_W'(MAX_BURST);
  end

  // A read command ends the write: its own cycle's beat is not taken.
  assign w_wr_beat       = ctl.wr_start | ((r_wr_state == ST_WR) & ~ctl.rd_start);
  assign ctl.wr_data_req = w_wr_beat;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_state <= ST_IDLE;
      r_wr_cnt   <= '0;
    end else if (ctl.wr_start) begin
      r_wr_cnt   <= w_len - LEN_W'(1);
      r_wr_state <= (w_len > LEN_W'(1)) ? ST_WR : ST_IDLE;
    end else if (r_wr_state == ST_WR) begin
      if (ctl.rd_start) begin
        r_wr_cnt   <= '0;
        r_wr_state <= ST_IDLE;
      end else begin
        r_wr_cnt <= r_wr_cnt - LEN_W'(1);
        if (r_wr_cnt == LEN_W'(1))
          r_wr_state <= ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dq_oe  <= 1'b0;
      r_dq_out <= '0;
      r_dqm    <= '0;
    end else begin
      r_dq_oe  <= w_wr_beat;
      r_dq_out <= w_wr_beat ? ctl.wr_data : r_dq_out;
      r_dqm    <= w_wr_beat ? ctl.wr_mask : '0;
    end
  end

  assign sdram_dq  = r_dq_oe ? r_dq_out : 'z;
  assign sdram_dqm = r_dqm;

  assign w_rd_pending = (|r_dl_vld) | (r_cap_cnt != '0);
  assign w_emerge     = r_dl_vld[DL_DEPTH-1];
  assign w_capture    = ~ctl.wr_start & (w_emerge | (r_cap_cnt != '0));

  // NOTE: the delay line is control state, so it is reset like any other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dl_vld <= '0;
      for (int i = 0; i < DL_DEPTH; i++) r_dl_len[i] <= '0;
    end else begin
      r_dl_vld    <= ctl.wr_start ? '0 : {r_dl_vld[DL_DEPTH-2:0], ctl.rd_start};
      r_dl_len[0] <= w_len;
      for (int i = 1; i < DL_DEPTH; i++) r_dl_len[i] <= r_dl_len[i-1];
    end
  end

  // An emerging read replaces any burst still capturing (read interrupts read).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cap_cnt <= '0;
    else if (ctl.wr_start)
      r_cap_cnt <= '0;
    else if (w_emerge)
      r_cap_cnt <= r_dl_len[DL_DEPTH-1] - LEN_W'(1);
    else if (r_cap_cnt != '0)
      r_cap_cnt <= r_cap_cnt - LEN_W'(1);
  end

`ifdef SDRAM_DQ_IOREG_EN
  logic [DATA_WIDTH-1:0] r_dq_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dq_in <= '0;
    else        r_dq_in <= sdram_dq;
  end

  assign w_dq_cap = r_dq_in;
`else
  assign w_dq_cap = sdram_dq;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_capture;
      if (w_capture) r_rd_data <= w_dq_cap;
    end
  end

  assign ctl.rd_data  = r_rd_data;
  assign ctl.rd_valid = r_rd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_conflict <= 1'b0;
    else if (ctl.wr_start & (ctl.rd_start | w_rd_pending))
      r_conflict <= 1'b1;
  end

  assign bus_conflict = r_conflict;

endmodule

// File: tb/tb_sdram_dq_path.sv
// Directed bench for sdram_dq_path: write/read bursts, interrupts, conflicts,
// reset. The released bus is pulled up, so high-Z reads as all ones.
module tb_sdram_dq_path;
  localparam int DW = 16;
  localparam int MW = 2;
  localparam int LW = 9;
  localparam logic [DW-1:0] HIZ = 16'hFFFF;
`ifdef SDRAM_DQ_IOREG_EN
  localparam int L = 1;
`else
  localparam int L = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  wire  [DW-1:0] w_dq;
  logic          tb_oe;
  logic [DW-1:0] tb_val;
  logic [MW-1:0] dqm;
  logic          conflict;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign w_dq = tb_oe ? tb_val : 'z;
  pullup (w_dq);

  sdram_dq_path_if #(.DATA_WIDTH(DW), .MASK_WIDTH(MW), .LEN_W(LW)) bus ();

  sdram_dq_path dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ctl          (bus.slave),
    .sdram_dq     (w_dq),
    .sdram_dqm    (dqm),
    .bus_conflict (conflict)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.wr_start  = 1'b0;
    bus.rd_start  = 1'b0;
    bus.burst_len = '0;
    bus.wr_data   = '0;
    bus.wr_mask   = '0;
    tb_oe         = 1'b0;
    tb_val        = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int s;
  int req_cnt;

  initial begin
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after reset: everything quiet, bus released
    for (int k = 0; k < 20; k++) begin
      idle_inputs();
      #1;
      check($sformatf("rst dq k=%0d", k), w_dq, HIZ);
      check($sformatf("rst dqm k=%0d", k), dqm, 0);
      check($sformatf("rst rd_valid k=%0d", k), bus.rd_valid, 0);
      check($sformatf("rst rd_data k=%0d", k), bus.rd_data, 0);
      check($sformatf("rst req k=%0d", k), bus.wr_data_req, 0);
      check($sformatf("rst conflict k=%0d", k), conflict, 0);
      next_cycle();
    end

    // Write N=4, mask 0,0,1,0
    for (int k = 0; k < 7; k++) begin
      idle_inputs();
      bus.wr_start  = (k == 0);
      bus.burst_len = 9'd4;
      bus.wr_data   = (k < 4) ? DW'(16'h1111 * (k + 1)) : 16'hDEAD;
      bus.wr_mask   = (k == 2) ? 2'b01 : 2'b00;
      #1;
      check($sformatf("wr4 req k=%0d", k), bus.wr_data_req, (k < 4) ? 1 : 0);
      check($sformatf("wr4 dq k=%0d", k), w_dq, (k >= 1 && k <= 4) ? 16'h1111 * k : HIZ);
      check($sformatf("wr4 dqm k=%0d", k), dqm, (k == 3) ? 1 : 0);
      next_cycle();
    end
    repeat (3) next_cycle();

    // Read N=8, memory drives 0xA000+i from T+4
    for (int k = 0; k < 16; k++) begin
      idle_inputs();
      bus.rd_start  = (k == 0);
      bus.burst_len = 9'd8;
      tb_oe  = (k >= 4 && k <= 11);
      tb_val = DW'(16'hA000 + k - 4);
      #1;
      s = k - 1 - L;
      check($sformatf("rd8 valid k=%0d", k), bus.rd_valid, (s >= 4 && s <= 11) ? 1 : 0);
      if (s >= 4 && s <= 11)
        check($sformatf("rd8 data k=%0d", k), bus.rd_data, 16'hA000 + s - 4);
      next_cycle();
    end
    repeat (3) next_cycle();

    // Read N=8 interrupted by read N=4 three cycles later
    for (int k = 0; k < 16; k++) begin
      idle_inputs();
      bus.rd_start  = (k == 0 || k == 3);
      bus.burst_len = (k == 0) ? 9'd8 : 9'd4;
      tb_oe  = (k >= 4 && k <= 10);
      tb_val = (k <= 6) ? DW'(16'hB000 + k - 4) : DW'(16'hC000 + k - 7);
      #1;
      s = k - 1 - L;
      check($sformatf("rdint valid k=%0d", k), bus.rd_valid, (s >= 4 && s <= 10) ? 1 : 0);
      if (s >= 4 && s <= 10)
        check($sformatf("rdint data k=%0d", k), bus.rd_data,
              (s <= 6) ? 16'hB000 + s - 4 : 16'hC000 + s - 7);
      next_cycle();
    end
    repeat (3) next_cycle();

    // Write N=8 terminated by rd_start (N=2) at T+3
    for (int k = 0; k < 13; k++) begin
      idle_inputs();
      bus.wr_start  = (k == 0);
      bus.rd_start  = (k == 3);
      bus.burst_len = (k == 0) ? 9'd8 : 9'd2;
      bus.wr_data   = DW'(16'h5000 + k);
      tb_oe  = (k == 7 || k == 8);
      tb_val = DW'(16'hD000 + k - 7);
      #1;
      s = k - 1 - L;
      check($sformatf("wrterm req k=%0d", k), bus.wr_data_req, (k < 3) ? 1 : 0);
      if (k <= 6)
        check($sformatf("wrterm dq k=%0d", k), w_dq, (k >= 1 && k <= 3) ? 16'h5000 + k - 1 : HIZ);
      check($sformatf("wrterm valid k=%0d", k), bus.rd_valid, (s == 7 || s == 8) ? 1 : 0);
      if (s == 7 || s == 8)
        check($sformatf("wrterm data k=%0d", k), bus.rd_data, 16'hD000 + s - 7);
      check($sformatf("wrterm conflict k=%0d", k), conflict, 0);
      next_cycle();
    end
    repeat (3) next_cycle();

    // Read at T, write N=2 at T+2: read dropped, conflict flagged
    for (int k = 0; k < 13; k++) begin
      idle_inputs();
      bus.rd_start  = (k == 0);
      bus.wr_start  = (k == 2);
      bus.burst_len = (k == 0) ? 9'd4 : 9'd2;
      bus.wr_data   = DW'(16'h6000 + k);
      #1;
      check($sformatf("conf req k=%0d", k), bus.wr_data_req, (k == 2 || k == 3) ? 1 : 0);
      check($sformatf("conf dq k=%0d", k), w_dq, (k == 3 || k == 4) ? 16'h6000 + k - 1 : HIZ);
      check($sformatf("conf valid k=%0d", k), bus.rd_valid, 0);
      check($sformatf("conf flag k=%0d", k), conflict, (k >= 3) ? 1 : 0);
      next_cycle();
    end

    // Reset asserted mid-write: outputs drop without waiting for a clock
    for (int k = 0; k < 4; k++) begin
      idle_inputs();
      bus.wr_start  = (k == 0);
      bus.burst_len = 9'd8;
      bus.wr_data   = DW'(16'h8000 + k);
      bus.wr_mask   = 2'b11;
      #1;
      if (k == 3) begin
        check("midrst dq before", w_dq, 16'h8002);
        rst_n = 1'b0;
        #1;
        check("midrst dq", w_dq, HIZ);
        check("midrst dqm", dqm, 0);
        check("midrst req", bus.wr_data_req, 0);
        check("midrst conflict", conflict, 0);
        check("midrst rd_data", bus.rd_data, 0);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    rst_n = 1'b1;
    repeat (2) next_cycle();
    check("post rst dq", w_dq, HIZ);

    // Simultaneous wr_start and rd_start: write wins
    for (int k = 0; k < 11; k++) begin
      idle_inputs();
      bus.wr_start  = (k == 0);
      bus.rd_start  = (k == 0);
      bus.burst_len = 9'd2;
      bus.wr_data   = DW'(16'h7000 + k);
      #1;
      check($sformatf("simul req k=%0d", k), bus.wr_data_req, (k <= 1) ? 1 : 0);
      check($sformatf("simul dq k=%0d", k), w_dq, (k == 1 || k == 2) ? 16'h7000 + k - 1 : HIZ);
      check($sformatf("simul valid k=%0d", k), bus.rd_valid, 0);
      check($sformatf("simul flag k=%0d", k), conflict, (k >= 1) ? 1 : 0);
      next_cycle();
    end

    // burst_len 0 behaves as one beat
    for (int k = 0; k < 4; k++) begin
      idle_inputs();
      bus.wr_start  = (k == 0);
      bus.burst_len = 9'd0;
      bus.wr_data   = (k == 0) ? 16'h1234 : 16'h9999;
      bus.wr_mask   = 2'b10;
      #1;
      check($sformatf("len0 req k=%0d", k), bus.wr_data_req, (k == 0) ? 1 : 0);
      check($sformatf("len0 dq k=%0d", k), w_dq, (k == 1) ? 16'h1234 : HIZ);
      check($sformatf("len0 dqm k=%0d", k), dqm, (k == 1) ? 2 : 0);
      next_cycle();
    end

    // burst_len above MAX_BURST clamps to 256 beats
    req_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      idle_inputs();
      bus.wr_start  = (k == 0);
      bus.burst_len = 9'h1FF;
      bus.wr_data   = DW'(k);
      #1;
      if (bus.wr_data_req) req_cnt++;
      next_cycle();
    end
    check("clamp beats", req_cnt, 256);
    check("clamp dq idle", w_dq, HIZ);
    check("sticky flag", conflict, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_dq_path.md
# sdram_dq_path

Parametrised SDRAM data-path block between the SDRAM command controller and the DQ/DQM pins. It drives write bursts onto the tristate DQ bus with per-byte masks and captures read bursts after a configurable CAS-derived delay. It supports variable burst length, read-interrupts-read and write-interrupts-anything semantics. It outputs a read-data-valid strobe so downstream FIFOs no longer decode controller state.

## Interface
- DATA_WIDTH, 16, DQ width in bits; multiple of 8.
- MASK_WIDTH, DATA_WIDTH/8, DQM width.
- RD_DELAY, 4, cycles from `rd_start` to first DQ sample (CL plus command register stage); range 2..15.
- MAX_BURST, 256, largest burst length accepted.
- LEN_W, 9, width of `burst_len`; must hold MAX_BURST.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_start  in  1  one-cycle pulse; write burst begins this cycle.
- rd_start  in  1  one-cycle pulse; READ command issued on pins next cycle.
- burst_len  in  LEN_W  beats, sampled with `wr_start`/`rd_start`; 0 treated as 1, values >MAX_BURST clamp to MAX_BURST.
- wr_data  in  DATA_WIDTH  write beat, sampled when `wr_data_req`=1.
- wr_mask  in  MASK_WIDTH  byte masks (1 = byte not written), sampled with `wr_data`.
- wr_data_req  out  1  combinational; high every cycle a write beat is consumed.
- rd_data  out  DATA_WIDTH  captured read beat.
- rd_valid  out  1  `rd_data` holds a valid beat this cycle.
- sdram_dqm  out  MASK_WIDTH  registered DQM pins.
- bus_conflict  out  1  sticky error flag.
- sdram_dq  inout  DATA_WIDTH  SDRAM data bus; high-Z unless driving.

## Operation
- Reset: `rd_data`=0, `rd_valid`=0, `sdram_dqm`=0, `bus_conflict`=0, DQ high-Z, `wr_data_req`=0, write/read counters and read delay line cleared.
- Write FSM states IDLE, WR. `wr_start` in any state loads the beat counter with N and enters WR. `wr_data_req`=1 in the start cycle and while count>0; each consumed beat decrements. Last beat returns to IDLE.
- Registered output: consumed beat and mask appear on DQ/DQM the next cycle with output enable high. Otherwise DQ high-Z and DQM=0.
- Read delay line: RD_DELAY-deep shift of {valid, N}. On emergence the capture counter loads N, replacing any burst in progress (read interrupts read; old burst truncated, no gap).
- Capture: while capture count>0, DQ sampled into `rd_data` and `rd_valid`=1 next cycle.
- `rd_start` during WR terminates the write. The bus is released the cycle after the last consumed beat, which is the `rd_start` cycle's beat excluded, so `wr_data_req`=0 in that cycle.
- `wr_start` while any read is pending in the delay line or capturing clears the delay line and capture counter and sets `bus_conflict`. The write proceeds. `bus_conflict` clears only on reset.
- Simultaneous `wr_start` and `rd_start`: write wins, read dropped, `bus_conflict` set.

## Timing
- Write: `wr_start` at cycle T, N beats. `wr_data_req` high T..T+N-1. DQ driven T+1..T+N. High-Z from T+N+1.
- Read: `rd_start` at T. DQ sampled at edges ending cycles T+RD_DELAY..T+RD_DELAY+N-1. `rd_valid` high T+RD_DELAY+1..T+RD_DELAY+N.
- Back-to-back reads every N cycles give a continuous `rd_valid`.
- Reset asserted mid-burst: outputs return to reset values asynchronously, and DQ goes high-Z immediately.

## Configuration
- SDRAM_DQ_IOREG_EN defined: extra input register on DQ before capture (pad register). `rd_valid`/`rd_data` arrive one cycle later (T+RD_DELAY+2..T+RD_DELAY+N+1). Write timing unchanged.
- Undefined: single capture stage as in Timing.

## Test plan
- Reset release, no stimulus -> DQ high-Z, all outputs 0 for 20 cycles.
- `wr_start`, N=4, data 0x1111..0x4444, mask 0,0,1,0 -> DQ 0x1111,0x2222,0x3333,0x4444 at T+1..T+4, DQM 0,0,1,0, high-Z at T+5.
- `rd_start`, N=8, RD_DELAY=4, model drives 0xA000+i from T+4 -> `rd_valid` T+5..T+12 with 0xA000..0xA007; with SDRAM_DQ_IOREG_EN, T+6..T+13.
- `rd_start` N=8 at T, second N=4 at T+3 -> 3 beats of burst 1 then 4 of burst 2, `rd_valid` continuous T+5..T+11.
- Write N=8 with `rd_start` at T+3 -> `wr_data_req` high T..T+2 only, DQ driven T+1..T+3.
- `rd_start` at T, `wr_start` at T+2 -> no `rd_valid`, write executes, `bus_conflict`=1 until reset.
